// File: rtl/ring_buffer_writer.sv
// ring_buffer_writer: producer side of the 4-entry MAC operand ring.
// Owns storage, write pointer/wrap, occupancy and pointer-error tracking.
module ring_buffer_writer #(
    parameter int BufferWidth = 2,
    parameter int BufferSize  = 4,
    parameter int DataWidth   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   In_Valid,
    input  logic [DataWidth-1:0]   In_Data,
    output logic                   In_Ready,
    input  logic                   Flush,
    input  logic [BufferWidth-1:0] R_Addr,
    input  logic                   R_Wrap,
    output logic [BufferWidth-1:0] W_Addr,
    output logic                   Round,
    output logic [BufferSize-1:0]  Free,
    output logic [BufferWidth:0]   Count,
    output logic [DataWidth-1:0]   Rd_Data,
    output logic                   Ptr_Err
);

    typedef enum logic [1:0] {
        S_EMPTY,
        S_PARTIAL,
        S_FULL,
        S_ERR
    } state_t;

    localparam logic [BufferWidth:0] SizeC = (BufferWidth+1)'(BufferSize);
    localparam logic [BufferWidth:0] OneC  = (BufferWidth+1)'(1);

    logic [DataWidth-1:0] mem [BufferSize];
    logic                 w_wrap;
    state_t               state;
    logic [BufferWidth:0] w_ptr;
    logic [BufferWidth:0] r_ptr;
    logic [BufferWidth:0] w_ptr_nxt;
    logic [BufferWidth:0] cnt_nxt;
    logic                 wr_fire;

    assign w_ptr    = {w_wrap, W_Addr};
    assign r_ptr    = {R_Wrap, R_Addr};
    assign Count    = w_ptr - r_ptr;
    assign In_Ready = (Count < SizeC) && !Flush && !Ptr_Err;
    assign wr_fire  = In_Valid && In_Ready;
    assign Round    = w_wrap ^ R_Wrap;
    assign Rd_Data  = mem[R_Addr];

    // Next write pointer; the wrap bit rides as the pointer MSB.
    always_comb begin
        w_ptr_nxt = w_ptr;
        if (Flush) begin
            w_ptr_nxt = r_ptr;
        end else if (wr_fire) begin
            w_ptr_nxt = w_ptr + OneC;
        end
        cnt_nxt = w_ptr_nxt - r_ptr;
    end

    // A slot is free when its distance from the read pointer is past the occupied span.
    always_comb begin
        Free = '0;
        for (int i = 0; i < BufferSize; i++) begin
            Free[i] = {1'b0, BufferWidth'(BufferWidth'(i) - R_Addr)} >= Count;
        end
    end

    // Write pointer and wrap bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            W_Addr <= '0;
            w_wrap <= 1'b0;
        end else begin
            {w_wrap, W_Addr} <= w_ptr_nxt;
        end
    end

    // Sticky error once the reader has overtaken the writer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Ptr_Err <= 1'b0;
        end else if (Count > SizeC) begin
            Ptr_Err <= 1'b1;
        end
    end

    // Occupancy state from next-cycle count; ERR holds until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_EMPTY;
        end else if (state == S_ERR || Ptr_Err || Count > SizeC) begin
            state <= S_ERR;
        end else if (cnt_nxt == '0) begin
            state <= S_EMPTY;
        end else if (cnt_nxt == SizeC) begin
            state <= S_FULL;
        end else begin
            state <= S_PARTIAL;
        end
    end

    // Storage is not reset; only accepted writes touch it.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[W_Addr] <= In_Data;
        end
    end

endmodule

// File: tb/tb_ring_buffer_writer.sv
// tb_ring_buffer_writer: scoreboard bench for ring_buffer_writer.
// Consumer pointer is driven by the bench; written data queued and popped on read.
module tb_ring_buffer_writer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        In_Valid = 1'b0;
    logic [15:0] In_Data = '0;
    logic        In_Ready;
    logic        Flush = 1'b0;
    logic [1:0]  R_Addr = '0;
    logic        R_Wrap = 1'b0;
    logic [1:0]  W_Addr;
    logic        Round;
    logic [3:0]  Free;
    logic [2:0]  Count;
    logic [15:0] Rd_Data;
    logic        Ptr_Err;

    int total = 0;
    int bad   = 0;

    logic [2:0]  w = '0;
    logic [2:0]  r = '0;
    logic        perr = 1'b0;
    logic [15:0] q[$];

    ring_buffer_writer dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .In_Valid(In_Valid),
        .In_Data (In_Data),
        .In_Ready(In_Ready),
        .Flush   (Flush),
        .R_Addr  (R_Addr),
        .R_Wrap  (R_Wrap),
        .W_Addr  (W_Addr),
        .Round   (Round),
        .Free    (Free),
        .Count   (Count),
        .Rd_Data (Rd_Data),
        .Ptr_Err (Ptr_Err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] mcnt();
        return w - r;
    endfunction

    function automatic logic [3:0] mfree();
        logic [3:0] f = 4'hf;
        logic [2:0] c = w - r;
        logic [1:0] idx;
        for (int j = 0; j < int'(c); j++) begin
            idx = r[1:0] + 2'(j);
            f[idx] = 1'b0;
        end
        return f;
    endfunction

    task automatic check_outs(input string tag);
        chk({tag, "_cnt"}, 32'(Count), 32'(mcnt()));
        chk({tag, "_waddr"}, 32'(W_Addr), 32'(w[1:0]));
        chk({tag, "_round"}, 32'(Round), 32'(w[2] ^ r[2]));
        chk({tag, "_free"}, 32'(Free), 32'(mfree()));
        chk({tag, "_perr"}, 32'(Ptr_Err), 32'(perr));
        if (q.size() > 0 && !perr)
            chk({tag, "_rdata"}, 32'(Rd_Data), 32'(q[0]));
    endtask

    task automatic step(input string tag, input logic v, input logic [15:0] d,
                        input logic f, input logic rd);
        logic exp_rdy;
        @(negedge clk);
        check_outs(tag);
        if (rd && q.size() > 0) begin
            void'(q.pop_front());
            r = r + 3'd1;
        end
        R_Addr   = r[1:0];
        R_Wrap   = r[2];
        In_Valid = v;
        In_Data  = d;
        Flush    = f;
        #1;
        exp_rdy = (mcnt() < 3'd4) && !f && !perr;
        chk({tag, "_rdy"}, 32'(In_Ready), 32'(exp_rdy));
        @(posedge clk);
        if (mcnt() > 3'd4) perr = 1'b1;
        if (f) begin
            w = r;
            q.delete();
        end else if (v && exp_rdy) begin
            q.push_back(d);
            w = w + 3'd1;
        end
        #1;
        In_Valid = 1'b0;
        Flush    = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n    = 1'b0;
        In_Valid = 1'b0;
        Flush    = 1'b0;
        r        = '0;
        R_Addr   = '0;
        R_Wrap   = 1'b0;
        w        = '0;
        perr     = 1'b0;
        q.delete();
        #1;
        check_outs(tag);
        chk({tag, "_rdy"}, 32'(In_Ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        do_reset("rst0");

        for (int k = 0; k < 4; k++)
            step("fill", 1'b1, 16'h00A1 + 16'(k), 1'b0, 1'b0);
        step("stall", 1'b1, 16'h00A5, 1'b0, 1'b0);
        chk("full_rdy", 32'(In_Ready), 32'd0);
        chk("full_free", 32'(Free), 32'h0);

        step("adv", 1'b0, 16'h0, 1'b0, 1'b1);
        step("refill", 1'b1, 16'h00B0, 1'b0, 1'b0);
        chk("refill_waddr", 32'(W_Addr), 32'd1);

        for (int k = 0; k < 4; k++)
            step("drain", 1'b0, 16'h0, 1'b0, 1'b1);
        step("seed", 1'b1, 16'h00D0, 1'b0, 1'b0);
        for (int k = 0; k < 12; k++)
            step("stream", 1'b1, 16'h00D1 + 16'(k), 1'b0, 1'b1);
        step("stream_end", 1'b0, 16'h0, 1'b0, 1'b1);

        do_reset("rst1");
        for (int k = 0; k < 3; k++)
            step("pre_fl", 1'b1, 16'h00E1 + 16'(k), 1'b0, 1'b0);
        step("flush", 1'b1, 16'h00EE, 1'b1, 1'b0);
        step("post_fl", 1'b0, 16'h0, 1'b0, 1'b0);
        chk("flush_free", 32'(Free), 32'hF);

        step("pre_err", 1'b1, 16'h0F01, 1'b0, 1'b0);
        @(negedge clk);
        r = w + 3'd1;
        R_Addr = r[1:0];
        R_Wrap = r[2];
        #1;
        chk("err_rdy", 32'(In_Ready), 32'd0);
        chk("err_cnt", 32'(Count), 32'd7);
        @(posedge clk);
        perr = 1'b1;
        #1;
        chk("err_set", 32'(Ptr_Err), 32'd1);
        @(negedge clk);
        r = w;
        R_Addr = r[1:0];
        R_Wrap = r[2];
        q.delete();
        step("err_hold", 1'b1, 16'h0F02, 1'b0, 1'b0);
        step("err_hold2", 1'b1, 16'h0F03, 1'b0, 1'b0);
        chk("err_sticky", 32'(Ptr_Err), 32'd1);

        do_reset("rst2");
        step("burst", 1'b1, 16'h0C01, 1'b0, 1'b0);
        step("burst", 1'b1, 16'h0C02, 1'b0, 1'b0);
        @(negedge clk);
        chk("mid_cnt", 32'(Count), 32'd2);
        do_reset("rst3");
        step("after", 1'b1, 16'h0C03, 1'b0, 1'b0);
        step("after2", 1'b0, 16'h0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
